// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: input sync, clock deglitch, 11-bit frame deframing.
// Define PS2_RX_PARITY_ERR_EN to check odd parity and expose the o_err strobe.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_en
`ifdef PS2_RX_PARITY_ERR_EN
  ,
  output logic       o_err
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic [FW-1:0]          flt_cnt;
  logic                   filt_clk;
  logic                   fall;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic       timeout;
  logic       frame_ok;
  logic       load;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      flt_cnt   <= '0;
      filt_clk  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
      fall      <= 1'b0;
      if (clk_s == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt_clk <= clk_s;
        flt_cnt  <= '0;
        fall     <= filt_clk;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_RX_PARITY_ERR_EN
  logic parity_q, parity_nxt;
  logic reject;
  assign frame_ok = data_s && (^{parity_q, shift_q});
`else
  assign frame_ok = data_s;
`endif

  assign timeout = (state != IDLE) && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    to_nxt    = '0;
    load      = 1'b0;
`ifdef PS2_RX_PARITY_ERR_EN
    parity_nxt = parity_q;
    reject     = 1'b0;
`endif
    if (timeout) begin
      state_nxt = IDLE;
    end else begin
      if (state != IDLE && !fall) to_nxt = to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s) begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end
          end
          DATA: begin
            shift_nxt = {data_s, shift_q[7:1]};
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_nxt = PARITY;
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_ERR_EN
            parity_nxt = data_s;
`endif
            state_nxt = STOP;
          end
          STOP: begin
            state_nxt = IDLE;
            load      = frame_ok;
`ifdef PS2_RX_PARITY_ERR_EN
            reject    = !frame_ok;
`endif
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Frame state and registered output strobes.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      to_cnt    <= '0;
      o_byte    <= 8'h00;
      o_byte_en <= 1'b0;
`ifdef PS2_RX_PARITY_ERR_EN
      parity_q  <= 1'b0;
      o_err     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      shift_q   <= shift_nxt;
      to_cnt    <= to_nxt;
      o_byte_en <= load;
      if (load) o_byte <= shift_q;
`ifdef PS2_RX_PARITY_ERR_EN
      parity_q  <= parity_nxt;
      o_err     <= reject;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomized self-checking bench for ps2_rx: frame-level model of expected strobes.
module tb_ps2_rx;

  localparam int TO   = 2000;
  localparam int HALF = 20;
`ifdef PS2_RX_PARITY_ERR_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_sclr_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] o_byte;
  logic       o_byte_en;
  logic       o_err_w;

  always #10 clk = ~clk;

  ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .i_sclr_n(i_sclr_n),
    .i_ps2_clk(ps2c),
    .i_ps2_data(ps2d),
    .o_byte(o_byte),
    .o_byte_en(o_byte_en)
`ifdef PS2_RX_PARITY_ERR_EN
    ,
    .o_err(o_err_w)
`endif
  );

`ifndef PS2_RX_PARITY_ERR_EN
  assign o_err_w = 1'b0;
`endif

  typedef struct {
    bit       isErr;
    bit [7:0] val;
    int       deadline;
  } exp_t;

  exp_t     expQ[$];
  logic [7:0] modelByte = 8'h00;
  int       cycle = 0;
  int       asserts = 0;
  int       failures = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    asserts++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // One PS/2 frame (or its first nBits bits); the model entry is queued at the stop-bit fall.
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit stopBit, input int nBits);
    logic [10:0] bits;
    bit good;
    bits = {stopBit, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2d = bits[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) begin
        good = stopBit && !(PAR_EN && badPar);
        if (good) expQ.push_back('{1'b0, b, cycle + 30});
        else if (PAR_EN) expQ.push_back('{1'b1, 8'h00, cycle + 30});
      end
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison of DUT outputs against the frame model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!i_sclr_n) begin
        modelByte = 8'h00;
        expQ.delete();
        checkOutput("reset_byte", o_byte, 0);
        checkOutput("reset_en", o_byte_en, 0);
        checkOutput("reset_err", o_err_w, 0);
      end else begin
        if (o_byte_en || o_err_w) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_strobe", {o_err_w, o_byte_en}, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("strobe_kind", {o_err_w, o_byte_en}, e.isErr ? 2'b10 : 2'b01);
            if (!e.isErr) modelByte = e.val;
          end
        end else if (expQ.size() > 0 && cycle > expQ[0].deadline) begin
          e = expQ.pop_front();
          checkOutput("missing_strobe", {o_err_w, o_byte_en}, e.isErr ? 2'b10 : 2'b01);
        end
        checkOutput("byte_value", o_byte, modelByte);
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    failures++;
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    idle(5);
    i_sclr_n = 1'b1;
    idle(10);

    // Reference frame 0x1C.
    applyStimulus(8'h1C, 0, 1, 11);
    idle(40);
    checkOutput("lit_1C", o_byte, 8'h1C);

    // Back-to-back F0 then 1C.
    applyStimulus(8'hF0, 0, 1, 11);
    applyStimulus(8'h1C, 0, 1, 11);
    idle(40);
    checkOutput("lit_b2b", o_byte, 8'h1C);

    // Corrupted parity on 0x1C: o_byte reads 1C either way.
    applyStimulus(8'h1C, 1, 1, 11);
    idle(40);
    checkOutput("lit_badpar", o_byte, 8'h1C);

    // Partial frame abandoned by timeout, then 0x32.
    applyStimulus(8'h6B, 0, 1, 5);
    idle(TO + 500);
    applyStimulus(8'h32, 0, 1, 11);
    idle(40);
    checkOutput("lit_timeout", o_byte, 8'h32);

    // Short low glitch with data low, spurious fall with data high, bad stop bit.
    ps2d = 1'b0;
    idle(20);
    ps2c = 1'b0;
    idle(3);
    ps2c = 1'b1;
    idle(20);
    ps2d = 1'b1;
    idle(20);
    ps2c = 1'b0;
    idle(HALF);
    ps2c = 1'b1;
    idle(40);
    applyStimulus(8'hA5, 0, 0, 11);
    idle(40);
    applyStimulus(8'h5A, 0, 1, 11);
    idle(40);
    checkOutput("lit_after_glitch", o_byte, 8'h5A);

    // Reset after the 5th falling edge, then 0x1C.
    applyStimulus(8'h77, 0, 1, 5);
    @(negedge clk);
    i_sclr_n = 1'b0;
    @(negedge clk);
    i_sclr_n = 1'b1;
    idle(5);
    applyStimulus(8'h1C, 0, 1, 11);
    idle(40);
    checkOutput("lit_after_reset", o_byte, 8'h1C);

    // Randomized frames with occasional corruption and partial frames.
    for (int k = 0; k < 30; k++) begin
      n = (k % 12 == 11) ? $urandom_range(1, 10) : 11;
      applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), n);
      if (n < 11) idle(TO + 100);
      else idle($urandom_range(0, 60));
    end

    idle(60);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
